// File: rtl/audio_mixer_pkg.sv
// audio_mixer_pkg: shared constants, FSM state type and 16-bit saturation
// helpers for the audio mixer and its optional DC blocker.
package audio_mixer_pkg;

  localparam int VOL_UNITY = 8;
  localparam int VOL_SHIFT = 3;
  localparam logic signed [15:0] OUT_MAX = 16'sh7FFF;
  localparam logic signed [15:0] OUT_MIN = 16'sh8000;

  typedef enum logic [2:0] {IDLE, CAPT, ACC, SAT, FILT, OUT} state_t;

  // Clamp a wide signed value into the 16-bit output range.
  function automatic logic signed [15:0] sat16(input logic signed [31:0] x);
    if (x > 32'sd32767) return OUT_MAX;
    else if (x < -32'sd32768) return OUT_MIN;
    else return x[15:0];
  endfunction

  // True when sat16 would have to clamp.
  function automatic logic clips16(input logic signed [31:0] x);
    return (x > 32'sd32767) || (x < -32'sd32768);
  endfunction

endpackage

// File: rtl/audio_dc_block.sv
// audio_dc_block: first-order DC blocker y = x - x_prev + y_prev - (y_prev >>> DC_K).
// Feedback state is held in 20 bits (saturated); the output is saturated to 16 bits.
// Instantiated by audio_mixer only when AUDIO_MIXER_DCBLOCK_EN is defined.
module audio_dc_block
  import audio_mixer_pkg::*;
#(
  parameter int DC_K = 10
)(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic signed [15:0] i_x,
  output logic signed [15:0] o_y,
  output logic               o_clip
);

  logic signed [15:0] r_x_prev;
  logic signed [19:0] r_y_prev;
  logic signed [21:0] w_y_full;

  function automatic logic signed [19:0] sat20(input logic signed [21:0] x);
    if (x > 22'sd524287) return 20'sh7FFFF;
    else if (x < -22'sd524288) return 20'sh80000;
    else return x[19:0];
  endfunction

  // 22 bits cover |x - x_prev| < 2^16 plus a 20-bit feedback term.
  assign w_y_full = 22'(i_x) - 22'(r_x_prev) + 22'(r_y_prev) - 22'(r_y_prev >>> DC_K);
  assign o_y      = sat16(32'(w_y_full));
  assign o_clip   = clips16(32'(w_y_full));

  // Advance the filter history once per mixed sample.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x_prev <= '0;
      r_y_prev <= '0;
    end else if (i_en) begin
      r_x_prev <= i_x;
      r_y_prev <= sat20(w_y_full);
    end
  end

endmodule

// File: rtl/audio_mixer.sv
// audio_mixer: time-multiplexed N-channel mixer. Captures all channels on a
// sample strobe, applies a 4-bit volume (8 = unity), accumulates one channel
// per clock, saturates to 16-bit signed and pulses out_valid. Reports clipping
// and dropped strobes. Optional DC blocker: define AUDIO_MIXER_DCBLOCK_EN.
module audio_mixer
  import audio_mixer_pkg::*;
#(
  parameter int          NCH           = 3,
  parameter int          IN_W          = 16,
  parameter logic [15:0] UNSIGNED_MASK = 16'h0000,
  parameter int          DC_K          = 10
)(
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic                   ce_sample,
  input  logic [NCH*IN_W-1:0]    ch_in,
  input  logic [NCH*4-1:0]       ch_vol,
  output logic signed [15:0]     out,
  output logic                   out_valid,
  output logic                   clip,
  output logic                   busy,
  output logic [7:0]             overrun_cnt
);

  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int ACC_W = 21 + $clog2(NCH);
  localparam logic [NCH-1:0] UNS = UNSIGNED_MASK[NCH-1:0];

  state_t                    r_state, w_state_nxt;
  logic [NCH*IN_W-1:0]       r_ch;
  logic [NCH*4-1:0]          r_vol;
  logic [IDX_W-1:0]          r_idx;
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [15:0]        r_out;
  logic                      r_clip;
  logic                      r_out_valid;
  logic                      r_busy;
  logic [7:0]                r_ovr;

  logic [IN_W-1:0]           w_slot;
  logic [IN_W-1:0]           w_t;
  logic [3:0]                w_vol;
  logic signed [15:0]        w_s;
  logic signed [20:0]        w_prod;
  logic signed [31:0]        w_shr;

  // Select the current channel and flip the MSB of offset-binary sources.
  always_comb begin
    w_slot = r_ch[int'(r_idx)*IN_W +: IN_W];
    w_vol  = r_vol[int'(r_idx)*4 +: 4];
    w_t    = w_slot;
    if (UNS[r_idx]) w_t[IN_W-1] = ~w_slot[IN_W-1];
  end

  // Left-align the slot into 16 bits: keep MSBs of wide slots, pad narrow ones.
  if (IN_W == 16) begin : g_align_eq
    assign w_s = w_t;
  end else if (IN_W > 16) begin : g_align_trunc
    assign w_s = w_t[IN_W-1 -: 16];
  end else begin : g_align_pad
    assign w_s = {w_t, {(16-IN_W){1'b0}}};
  end

  assign w_prod = w_s * $signed({1'b0, w_vol});
  assign w_shr  = 32'(r_acc >>> VOL_SHIFT);

`ifdef AUDIO_MIXER_DCBLOCK_EN
  logic signed [15:0] w_dc_y;
  logic               w_dc_clip;

  audio_dc_block #(.DC_K(DC_K)) u_dc_block (
    .i_clk   (clk_sys),
    .i_rst_n (reset_n),
    .i_en    (r_state == FILT),
    .i_x     (r_out),
    .o_y     (w_dc_y),
    .o_clip  (w_dc_clip)
  );
`else
  logic w_unused_dc_k;
  assign w_unused_dc_k = (DC_K != 0);
`endif

  // Next-state logic for the capture / accumulate / saturate sequence.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (ce_sample) w_state_nxt = CAPT;
      CAPT: w_state_nxt = ACC;
      ACC:  if (r_idx == IDX_W'(NCH-1)) w_state_nxt = SAT;
`ifdef AUDIO_MIXER_DCBLOCK_EN
      SAT:  w_state_nxt = FILT;
      FILT: w_state_nxt = OUT;
`else
      SAT:  w_state_nxt = OUT;
`endif
      OUT:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register with registered valid/busy flags decoded from next state.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= (w_state_nxt == OUT);
      r_busy      <= (w_state_nxt != IDLE);
    end
  end

  // Datapath: latch inputs, accumulate one product per cycle, saturate result.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_ch   <= '0;
      r_vol  <= '0;
      r_idx  <= '0;
      r_acc  <= '0;
      r_out  <= '0;
      r_clip <= 1'b0;
    end else begin
      case (r_state)
        CAPT: begin
          r_ch  <= ch_in;
          r_vol <= ch_vol;
          r_acc <= '0;
          r_idx <= '0;
        end
        ACC: begin
          r_acc <= r_acc + ACC_W'(w_prod);
          r_idx <= r_idx + 1'b1;
        end
        SAT: begin
          r_out  <= sat16(w_shr);
          r_clip <= clips16(w_shr);
        end
`ifdef AUDIO_MIXER_DCBLOCK_EN
        FILT: begin
          r_out  <= w_dc_y;
          r_clip <= r_clip | w_dc_clip;
        end
`endif
        default: ;
      endcase
    end
  end

  // Count strobes that arrive while a mix is in progress, sticking at 255.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) r_ovr <= '0;
    else if (ce_sample && (r_state != IDLE) && (r_ovr != 8'hFF)) r_ovr <= r_ovr + 8'd1;
  end

  assign out         = r_out;
  assign clip        = r_clip;
  assign out_valid   = r_out_valid;
  assign busy        = r_busy;
  assign overrun_cnt = r_ovr;

endmodule

// File: tb/tb_audio_mixer.sv
// tb_audio_mixer: table-driven and randomized bench for audio_mixer
// (NCH=3, IN_W=16, channel 1 offset-binary), with a behavioural reference model.
`timescale 1ns/1ps
module tb_audio_mixer;

  localparam int NCH = 3;
  localparam int IN_W = 16;
  localparam logic [15:0] UMASK = 16'h0002;
  localparam int DCK = 10;
`ifdef AUDIO_MIXER_DCBLOCK_EN
  localparam int LAT = NCH + 4;
`else
  localparam int LAT = NCH + 3;
`endif

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  logic ce_sample = 1'b0;
  logic [NCH*IN_W-1:0] ch_in = '0;
  logic [NCH*4-1:0] ch_vol = '0;
  logic signed [15:0] out;
  logic out_valid, clip, busy;
  logic [7:0] overrun_cnt;

  int n_chk = 0;
  int n_fail = 0;
  longint m_xp = 0;
  longint m_yp = 0;

  typedef struct {
    logic [47:0] ch;
    logic [11:0] vol;
    logic [15:0] eo;
    logic        ec;
  } vec_t;

  always #5 clk_sys = ~clk_sys;

  audio_mixer #(.NCH(NCH), .IN_W(IN_W), .UNSIGNED_MASK(UMASK), .DC_K(DCK)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce_sample(ce_sample),
    .ch_in(ch_in), .ch_vol(ch_vol), .out(out), .out_valid(out_valid),
    .clip(clip), .busy(busy), .overrun_cnt(overrun_cnt)
  );

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint floor_div(input longint a, input longint b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  function automatic longint clamp(input longint v, input longint lo, input longint hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Reference: offset-binary -> two's complement, weighted sum /8 with floor, clamp.
  function automatic void model(input logic [47:0] ch, input logic [11:0] vol, output int eo, output logic ec);
    longint sum, r, full;
    int s;
    sum = 0;
    for (int i = 0; i < NCH; i++) begin
      if (UMASK[i]) s = int'(ch[i*16 +: 16]) - 32768;
      else          s = int'($signed(ch[i*16 +: 16]));
      sum += longint'(s) * longint'(vol[i*4 +: 4]);
    end
    r  = floor_div(sum, 8);
    eo = int'(clamp(r, -32768, 32767));
    ec = (r != eo);
`ifdef AUDIO_MIXER_DCBLOCK_EN
    full = eo - m_xp + m_yp - floor_div(m_yp, longint'(1) << DCK);
    m_xp = eo;
    m_yp = clamp(full, -524288, 524287);
    eo   = int'(clamp(full, -32768, 32767));
    ec   = ec | (full != eo);
`else
    full = 0;
`endif
  endfunction

  // One strobe; inputs are scrambled after capture. lat = cycle of first out_valid.
  task automatic run_sample(input logic [47:0] ch, input logic [11:0] vol,
                            output logic signed [15:0] o, output logic c,
                            output int lat, output int nv, output logic bm);
    o = '0; c = 1'b0; lat = -1; nv = 0;
    @(negedge clk_sys); ch_in = ch; ch_vol = vol; ce_sample = 1'b1;
    @(negedge clk_sys); ce_sample = 1'b0; bm = busy;
    for (int k = 2; k <= LAT + 4; k++) begin
      @(negedge clk_sys);
      if (k == 2) begin
        ch_in  = 48'({$urandom, $urandom});
        ch_vol = 12'($urandom);
      end
      if (out_valid) begin
        nv++;
        if (lat < 0) begin lat = k; o = out; c = clip; end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[12];
    logic signed [15:0] o;
    logic c, bm, ec;
    int lat, nv, eo;
    logic [47:0] ch;
    logic [11:0] vol;

    tbl[0]  = '{ch:{16'h5555,16'hAAAA,16'h1234}, vol:{4'd0,4'd0,4'd8},   eo:16'h1234, ec:1'b0};
    tbl[1]  = '{ch:{16'h0000,16'h8000,16'h0100}, vol:{4'd0,4'd8,4'd8},   eo:16'h0100, ec:1'b0};
    tbl[2]  = '{ch:{16'h1111,16'hFFFF,16'h2222}, vol:{4'd0,4'd8,4'd0},   eo:16'h7FFF, ec:1'b0};
    tbl[3]  = '{ch:{16'h7FFF,16'h7FFF,16'h7FFF}, vol:{4'd15,4'd15,4'd15},eo:16'h7FFF, ec:1'b1};
    tbl[4]  = '{ch:{16'h8000,16'h8000,16'h8000}, vol:{4'd15,4'd15,4'd15},eo:16'h8000, ec:1'b1};
    tbl[5]  = '{ch:{16'h0000,16'h0000,16'hFFFF}, vol:{4'd0,4'd0,4'd1},   eo:16'hFFFF, ec:1'b0};
    tbl[6]  = '{ch:{16'h0010,16'h0000,16'h0008}, vol:{4'd15,4'd0,4'd8},  eo:16'h0026, ec:1'b0};
    tbl[7]  = '{ch:{16'h7FFF,16'h0000,16'h0001}, vol:{4'd8,4'd0,4'd8},   eo:16'h7FFF, ec:1'b1};
    tbl[8]  = '{ch:{16'h0000,16'h0000,16'h8000}, vol:{4'd0,4'd0,4'd8},   eo:16'h8000, ec:1'b0};
    tbl[9]  = '{ch:{16'h0000,16'h0000,16'h1000}, vol:{4'd0,4'd0,4'd15},  eo:16'h1E00, ec:1'b0};
    tbl[10] = '{ch:{16'h0000,16'h0000,16'hFFFF}, vol:{4'd0,4'd8,4'd8},   eo:16'h8000, ec:1'b1};
    tbl[11] = '{ch:{16'h7FFF,16'hFFFF,16'h7FFF}, vol:{4'd0,4'd0,4'd0},   eo:16'h0000, ec:1'b0};

    // Reset held with toggling inputs
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_sys);
      ch_in = 48'({$urandom, $urandom}); ch_vol = 12'($urandom); ce_sample = 1'(i % 2);
    end
    @(negedge clk_sys);
    check("rst_out", out, 0);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_clip", clip, 0);
    check("rst_ovr", overrun_cnt, 0);
    ce_sample = 1'b0; reset_n = 1'b1;
    repeat (4) @(negedge clk_sys);
    check("idle_out", out, 0);
    check("idle_valid", out_valid, 0);
    check("idle_busy", busy, 0);
    check("idle_ovr", overrun_cnt, 0);

`ifndef AUDIO_MIXER_DCBLOCK_EN
    for (int i = 0; i < 12; i++) begin
      run_sample(tbl[i].ch, tbl[i].vol, o, c, lat, nv, bm);
      check($sformatf("vec%0d_out", i), o, $signed(tbl[i].eo));
      check($sformatf("vec%0d_clip", i), c, tbl[i].ec);
      check($sformatf("vec%0d_lat", i), lat, LAT);
      check($sformatf("vec%0d_npulse", i), nv, 1);
      check($sformatf("vec%0d_busy_capt", i), bm, 1);
      check($sformatf("vec%0d_busy_end", i), busy, 0);
    end
`endif

    for (int i = 0; i < 40; i++) begin
      ch  = 48'({$urandom, $urandom});
      vol = 12'($urandom);
      if (i % 4 == 0) begin
        for (int j = 0; j < NCH; j++) ch[j*16 +: 16] = ($urandom_range(0, 1) == 1) ? 16'h7FFF : 16'h8000;
      end
      model(ch, vol, eo, ec);
      run_sample(ch, vol, o, c, lat, nv, bm);
      check($sformatf("rnd%0d_out", i), o, eo);
      check($sformatf("rnd%0d_clip", i), c, ec);
      check($sformatf("rnd%0d_lat", i), lat, LAT);
      check($sformatf("rnd%0d_npulse", i), nv, 1);
    end

    // One dropped strobe two cycles after the accepted one
    ch = {16'h0000, 16'h8000, 16'h0200}; vol = {4'd0, 4'd8, 4'd8};
    model(ch, vol, eo, ec);
    @(negedge clk_sys); ch_in = ch; ch_vol = vol; ce_sample = 1'b1;
    @(negedge clk_sys); ce_sample = 1'b0;
    @(negedge clk_sys); ce_sample = 1'b1;
    @(negedge clk_sys); ce_sample = 1'b0;
    nv = 0; o = '0;
    for (int k = 4; k <= LAT + 6; k++) begin
      @(negedge clk_sys);
      if (out_valid) begin nv++; o = out; end
    end
    check("ovr1_npulse", nv, 1);
    check("ovr1_out", o, eo);
    check("ovr1_cnt", overrun_cnt, 1);

    // Strobe held four cycles: three more drops
    model(ch, vol, eo, ec);
    @(negedge clk_sys); ce_sample = 1'b1;
    repeat (3) @(negedge clk_sys);
    @(negedge clk_sys); ce_sample = 1'b0;
    nv = 0;
    for (int k = 4; k <= LAT + 6; k++) begin
      @(negedge clk_sys);
      if (out_valid) begin nv++; o = out; end
    end
    check("ovr4_npulse", nv, 1);
    check("ovr4_out", o, eo);
    check("ovr4_cnt", overrun_cnt, 4);

    // Hundreds of dropped strobes saturate the counter
    @(negedge clk_sys); ce_sample = 1'b1;
    repeat (2000) @(negedge clk_sys);
    ce_sample = 1'b0;
    repeat (LAT + 4) @(negedge clk_sys);
    check("ovr_sat_cnt", overrun_cnt, 255);
    check("ovr_sat_busy", busy, 0);

    // Asynchronous reset during accumulation
    ch = {16'h0000, 16'h0000, 16'h3000}; vol = {4'd0, 4'd0, 4'd8};
    @(negedge clk_sys); ch_in = ch; ch_vol = vol; ce_sample = 1'b1;
    @(negedge clk_sys); ce_sample = 1'b0;
    @(negedge clk_sys);
    check("midrst_busy_before", busy, 1);
    #1 reset_n = 1'b0;
    #1;
    check("midrst_out", out, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_clip", clip, 0);
    check("midrst_ovr", overrun_cnt, 0);
    m_xp = 0; m_yp = 0;
    @(negedge clk_sys);
    @(negedge clk_sys); reset_n = 1'b1;
    nv = 0;
    repeat (LAT + 4) begin
      @(negedge clk_sys);
      if (out_valid) nv++;
    end
    check("midrst_no_pulse", nv, 0);
    check("midrst_out_hold", out, 0);

    // Recovery after reset
    model(ch, vol, eo, ec);
    run_sample(ch, vol, o, c, lat, nv, bm);
    check("recover_out", o, eo);
    check("recover_lat", lat, LAT);

`ifdef AUDIO_MIXER_DCBLOCK_EN
    begin
      int mism, viol, prev, got;
      mism = 0; viol = 0; prev = 32767;
      reset_n = 1'b0; @(negedge clk_sys); reset_n = 1'b1; m_xp = 0; m_yp = 0;
      ch = {32'h0, 16'h4000}; vol = {8'h0, 4'd8};
      ch_in = ch; ch_vol = vol;
      for (int n = 0; n < 8000; n++) begin
        @(negedge clk_sys); ce_sample = 1'b1;
        @(negedge clk_sys); ce_sample = 1'b0;
        got = 0;
        for (int k = 2; k <= LAT + 1; k++) begin
          @(negedge clk_sys);
          if (out_valid) begin got = 1; o = out; end
        end
        model(ch, vol, eo, ec);
        if (got == 0 || int'(o) != eo) mism++;
        if (int'(o) > prev) viol++;
        prev = int'(o);
      end
      check("dc_model_mismatches", mism, 0);
      check("dc_monotonic_violations", viol, 0);
      check("dc_final_settled", (int'(o) >= 0 && int'(o) < 1024), 1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
